// File: rtl/rv32i_dmem_responder_if.sv
// Data-memory bus between an RV32I core (master) and a memory responder (slave).
interface rv32i_dmem_responder_if;
   logic        dmem_en;
   logic        dmem_wen;
   logic [2:0]  dmem_size;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata_delayed;
   logic        dmem_wait;
   logic [31:0] dmem_rdata;
   logic        dmem_badmem_e;

   modport master (
      output dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
      input  dmem_wait, dmem_rdata, dmem_badmem_e
   );

   modport slave (
      input  dmem_en, dmem_wen, dmem_size, dmem_addr, dmem_wdata_delayed,
      output dmem_wait, dmem_rdata, dmem_badmem_e
   );
endinterface

// File: rtl/rv32i_dmem_responder.sv
// Pipelined data-memory responder: address phase is registered, the data phase
// completes after WAIT_STATES stall cycles, with byte-lane stores and error flagging.
module rv32i_dmem_responder #(
   parameter int unsigned WORDS       = 1024,
   parameter int unsigned WAIT_STATES = 0
) (
   input logic                   clk,
   input logic                   reset,
   rv32i_dmem_responder_if.slave bus_io
);
   localparam int unsigned AddrW = $clog2(WORDS);

   typedef enum logic [1:0] {StIdle, StWait, StLast} state_e;

   state_e      state_q, state_d;
   logic [3:0]  wcnt_q, wcnt_d;
   logic        wen_q, wen_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] addr_q, addr_d;

   logic             accept;
   logic             err;
   logic [3:0]       be;
   logic [AddrW-1:0] idx;

   // Backing store; deliberately never reset or initialised.
   logic [31:0] mem [WORDS];

   // A new address phase is taken whenever the bus is not stalled.
   assign accept = bus_io.dmem_en && (state_q != StWait);
   assign idx    = addr_q[AddrW+1:2];

   // Out-of-range word, illegal size, or misaligned half/word access.
   assign err = (addr_q[31:AddrW+2] != '0) ||
                (size_q == 2'd3) ||
                ((size_q == 2'd1) && addr_q[0]) ||
                ((size_q == 2'd2) && (addr_q[1:0] != 2'd0));

   // Next-state: count down stall cycles, finish in LAST, overlap a new accept.
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      wen_d   = wen_q;
      size_d  = size_q;
      addr_d  = addr_q;
      unique case (state_q)
         StWait: begin
            wcnt_d = wcnt_q - 4'd1;
            if (wcnt_q == 4'd1) state_d = StLast;
         end
         StLast:  state_d = StIdle;
         default: ;
      endcase
      if (accept) begin
         state_d = (WAIT_STATES == 0) ? StLast : StWait;
         wcnt_d  = 4'(WAIT_STATES);
         wen_d   = bus_io.dmem_wen;
         size_d  = bus_io.dmem_size[1:0];
         addr_d  = bus_io.dmem_addr;
      end
   end

   // Request and phase registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         wcnt_q  <= 4'd0;
         wen_q   <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         wen_q   <= wen_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
      end
   end

   // Byte-lane enables for the registered store.
   always_comb begin
      be = 4'b0000;
      unique case (size_q)
         2'd0:    be[addr_q[1:0]] = 1'b1;
         2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
         2'd2:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
   end

   // Store commits on the edge that ends LAST; reset or error suppresses it.
   always_ff @(posedge clk) begin
      if (!reset && (state_q == StLast) && wen_q && !err) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= bus_io.dmem_wdata_delayed[8*b +: 8];
         end
      end
   end

   // Outputs are decoded from state only, so reset clears them immediately.
   always_comb begin
      bus_io.dmem_wait     = (state_q == StWait);
      bus_io.dmem_badmem_e = (state_q == StLast) && err;
      bus_io.dmem_rdata    = 32'd0;
      if ((state_q == StLast) && !wen_q && !err) bus_io.dmem_rdata = mem[idx];
   end
endmodule
